// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver delivering validated scan-code bytes
//   clock, reset          host clock, async active-high reset
//   ps2_clk, ps2_dat      raw PS/2 pins (asynchronous)
//   ps2_data, ps2_hit     received byte and its one-cycle strobe
//   parity_err, frame_err one-cycle drop strobes (bad parity / bad stop or timeout)
module ps2_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 25000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_data,
    output logic       ps2_hit,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic clk_s1, clk_s2, dat_s1, dat_s2, clk_f, clk_f_d, fall, par, timeout;
    logic hit_n, perr_n, ferr_n;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0] bitcnt;
    logic [7:0] sreg;
    assign fall    = clk_f_d & ~clk_f;
    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {clk_s1, clk_s2, dat_s1, dat_s2, clk_f, clk_f_d} <= '1;
            flt_cnt <= '0;
        end else begin
            {clk_s2, clk_s1} <= {clk_s1, ps2_clk};
            {dat_s2, dat_s1} <= {dat_s1, ps2_dat};
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f)
                flt_cnt <= '0;
            else if (flt_cnt == FW'(FILTER - 1)) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else
                flt_cnt <= flt_cnt + FW'(1);
        end
    end
    // fall takes priority over timeout, so a late edge still advances the frame
    always_comb begin
        state_n = state;
        hit_n   = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        if (fall) begin
            case (state)
                IDLE:    state_n = dat_s2 ? IDLE : DATA;
                DATA:    state_n = (bitcnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: begin
                    state_n = IDLE;
                    hit_n   = dat_s2 & (^{sreg, par});
                    perr_n  = dat_s2 & ~(^{sreg, par});
                    ferr_n  = ~dat_s2;
                end
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            sreg       <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            ps2_data   <= '0;
            ps2_hit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            ps2_hit    <= hit_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            to_cnt     <= (fall || state == IDLE) ? '0 : to_cnt + TW'(1);
            if (hit_n)
                ps2_data <= sreg;
            if (fall) begin
                case (state)
                    IDLE: begin
                        bitcnt <= '0;
                        sreg   <= '0;
                    end
                    DATA: begin
                        sreg   <= {dat_s2, sreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY:  par <= dat_s2;
                    default: ;
                endcase
            end
        end
    end
endmodule
